// File: rtl/pcs_rx_sm.sv
// pcs_rx_sm: 1000BASE-X PCS receive state machine (code groups -> GMII, RUDI to auto-negotiation).
// Three-stage lookahead pipeline s2->s1->s0; all outputs registered, group at edge n appears at edge n+3.
module pcs_rx_sm #(
   parameter logic [7:0] PREAMBLE_BYTE = 8'h55,
   parameter logic [7:0] EXT_BYTE      = 8'h0F,
   parameter logic [7:0] FC_BYTE       = 8'h0E
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sync_status,
   input  logic [7:0]  rx_code_group,
   input  logic        rx_control,
   input  logic        rx_code_err,
   output logic [7:0]  RXD,
   output logic        RX_DV,
   output logic        RX_ER,
   output logic [15:0] rx_Config_Reg,
   output logic        RUDI_C,
   output logic        RUDI_I,
   output logic        RUDI_INV,
   output logic        receiving,
   output logic        rx_even
);
   localparam logic [7:0] K28_5 = 8'hBC;
   localparam logic [7:0] K_S   = 8'hFB;
   localparam logic [7:0] K_T   = 8'hFD;
   localparam logic [7:0] K_R   = 8'hF7;
   localparam logic [7:0] D21_5 = 8'hB5;
   localparam logic [7:0] D2_2  = 8'h42;
   localparam logic [7:0] D5_6  = 8'hC5;
   localparam logic [7:0] D16_2 = 8'h50;

   // SOP, TRI and EARLY_END are single-group actions taken on the transition out of the deciding state
   typedef enum logic [3:0] {
      LINK_FAILED, WAIT_K, RX_K, RX_CB, RX_CC, RX_CD,
      IDLE_D, RECEIVE, TRR_EXT, FALSE_CARRIER
   } state_t;

   state_t      state_q, state_d;
   logic [9:0]  s2_q, s1_q, s0_q, s2_d, s1_d, s0_d;   // {ctrl, err, octet}
   logic        even_q, even_d;
   logic [7:0]  lo_q, lo_d, rxd_q, rxd_d;
   logic [15:0] cfg_q, cfg_d;
   logic        dv_q, dv_d, er_q, er_d, rcv_q, rcv_d;
   logic        rudi_c_q, rudi_c_d, rudi_i_q, rudi_i_d, rudi_inv_q, rudi_inv_d;

   function automatic logic is_k(input logic [9:0] g, input logic [7:0] code);
      return g[9] & ~g[8] & (g[7:0] == code);
   endfunction

   function automatic logic is_d(input logic [9:0] g, input logic [7:0] code);
      return ~g[9] & ~g[8] & (g[7:0] == code);
   endfunction

   logic s0_k285, s0_s, s0_dok, s0_cfg, s0_idl, s1_cfg_idl, check_end, check_trr, early_end;

   assign s0_k285    = is_k(s0_q, K28_5);
   assign s0_s       = is_k(s0_q, K_S);
   assign s0_dok     = ~s0_q[9] & ~s0_q[8];
   assign s0_cfg     = is_d(s0_q, D21_5) | is_d(s0_q, D2_2);
   assign s0_idl     = is_d(s0_q, D5_6) | is_d(s0_q, D16_2);
   assign s1_cfg_idl = is_d(s1_q, D21_5) | is_d(s1_q, D2_2) | is_d(s1_q, D5_6) | is_d(s1_q, D16_2);
   assign check_end  = is_k(s0_q, K_T) & is_k(s1_q, K_R) & is_k(s2_q, K28_5);
   assign check_trr  = is_k(s0_q, K_T) & is_k(s1_q, K_R) & is_k(s2_q, K_R);
   assign early_end  = s0_k285 & s1_cfg_idl;

   always_comb begin
      s2_d   = {rx_control, rx_code_err, rx_code_group};
      s1_d   = s2_q;
      s0_d   = s1_q;
      even_d = is_k(s1_q, K28_5) ? 1'b1 : ~even_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= LINK_FAILED;
         s2_q       <= '0;
         s1_q       <= '0;
         s0_q       <= '0;
         even_q     <= 1'b0;
         lo_q       <= '0;
         cfg_q      <= '0;
         rxd_q      <= '0;
         dv_q       <= 1'b0;
         er_q       <= 1'b0;
         rcv_q      <= 1'b0;
         rudi_c_q   <= 1'b0;
         rudi_i_q   <= 1'b0;
         rudi_inv_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         s2_q       <= s2_d;
         s1_q       <= s1_d;
         s0_q       <= s0_d;
         even_q     <= even_d;
         lo_q       <= lo_d;
         cfg_q      <= cfg_d;
         rxd_q      <= rxd_d;
         dv_q       <= dv_d;
         er_q       <= er_d;
         rcv_q      <= rcv_d;
         rudi_c_q   <= rudi_c_d;
         rudi_i_q   <= rudi_i_d;
         rudi_inv_q <= rudi_inv_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (!sync_status) state_d = LINK_FAILED;
      else begin
         case (state_q)
            LINK_FAILED:   state_d = WAIT_K;
            WAIT_K:        if (s0_k285) state_d = RX_K;
            RX_K:          state_d = s0_cfg ? RX_CB : (s0_idl ? IDLE_D : WAIT_K);
            RX_CB:         state_d = s0_dok ? RX_CC : WAIT_K;
            RX_CC:         state_d = s0_dok ? RX_CD : WAIT_K;
            RX_CD:         state_d = s0_k285 ? RX_K : WAIT_K;
            IDLE_D:        state_d = s0_k285 ? RX_K : ((s0_s && even_q) ? RECEIVE : FALSE_CARRIER);
            RECEIVE:       if (check_end) state_d = WAIT_K;
                           else if (check_trr) state_d = TRR_EXT;
                           else if (early_end) state_d = RX_K;
            TRR_EXT:       if (s0_s) state_d = RECEIVE;
                           else if (s0_k285) state_d = RX_K;
            FALSE_CARRIER: if (s0_k285 && even_q) state_d = RX_K;
            default:       state_d = LINK_FAILED;
         endcase
      end
   end

   // The config word is committed as the hi octet is accepted, so it lands with that group's slot
   always_comb begin
      rxd_d      = '0;
      dv_d       = 1'b0;
      er_d       = 1'b0;
      rcv_d      = rcv_q;
      rudi_c_d   = 1'b0;
      rudi_i_d   = 1'b0;
      rudi_inv_d = 1'b0;
      cfg_d      = cfg_q;
      lo_d       = lo_q;
      if (!sync_status) begin
         er_d  = rcv_q;
         rcv_d = 1'b0;
      end else begin
         case (state_q)
            RX_K: begin
               if (s0_idl) rudi_i_d = 1'b1;
               else if (!s0_cfg) rudi_inv_d = 1'b1;
            end
            RX_CB: begin
               if (s0_dok) lo_d = s0_q[7:0];
               else rudi_inv_d = 1'b1;
            end
            RX_CC: begin
               if (s0_dok) begin
                  cfg_d    = {s0_q[7:0], lo_q};
                  rudi_c_d = 1'b1;
               end else rudi_inv_d = 1'b1;
            end
            RX_CD: if (!s0_k285) rudi_inv_d = 1'b1;
            IDLE_D: begin
               if (s0_k285) begin
               end else if (s0_s && even_q) begin
                  rxd_d = PREAMBLE_BYTE;
                  dv_d  = 1'b1;
                  rcv_d = 1'b1;
               end else begin
                  rxd_d = FC_BYTE;
                  er_d  = 1'b1;
               end
            end
            RECEIVE: begin
               if (check_end) rcv_d = 1'b0;
               else if (check_trr) begin
                  rxd_d = EXT_BYTE;
                  er_d  = 1'b1;
               end else if (early_end) begin
                  er_d  = 1'b1;
                  rcv_d = 1'b0;
               end else begin
                  rxd_d = s0_q[7:0];
                  dv_d  = 1'b1;
                  er_d  = ~s0_dok;
               end
            end
            TRR_EXT: begin
               if (s0_s) begin
                  rxd_d = PREAMBLE_BYTE;
                  dv_d  = 1'b1;
                  rcv_d = 1'b1;
               end else if (s0_k285) rcv_d = 1'b0;
               else begin
                  rxd_d = EXT_BYTE;
                  er_d  = 1'b1;
               end
            end
            FALSE_CARRIER: begin
               if (!(s0_k285 && even_q)) begin
                  rxd_d = FC_BYTE;
                  er_d  = 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign RXD           = rxd_q;
   assign RX_DV         = dv_q;
   assign RX_ER         = er_q;
   assign rx_Config_Reg = cfg_q;
   assign RUDI_C        = rudi_c_q;
   assign RUDI_I        = rudi_i_q;
   assign RUDI_INV      = rudi_inv_q;
   assign receiving     = rcv_q;
   assign rx_even       = even_q;
endmodule
